// File: rtl/dpram_rd_arb_pkg.sv
// Shared constants for the two-requester read arbiter in front of the dual-port RAM.
package dpram_rd_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/dpram_rd_arb_ram.sv
// Simple synchronous dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module dpram_rd_arb_ram
  import dpram_rd_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dpram_rd_arb.sv
// Round-robin arbiter sharing one RAM read port between two requesters.
// Define DPRAM_RD_ARB_BYPASS_EN to forward same-cycle write data on a read/write collision.
module dpram_rd_arb
  import dpram_rd_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd0_req,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd0_gnt,
  output logic                  rd1_gnt,
  output logic                  rd0_valid,
  output logic                  rd1_valid,
  output logic [DATA_WIDTH-1:0] rd0_data,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic                  rd_collision
);

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  last_q, last_d;
  logic                  vld0_q, vld0_d;
  logic                  vld1_q, vld1_d;
  logic                  coll_q, coll_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
`ifdef DPRAM_RD_ARB_BYPASS_EN
  logic [DATA_WIDTH-1:0] byp_q, byp_d;
`endif

  // last_q names the most recent winner; contention goes to the other requester.
  always_comb begin
    rd0_gnt = 1'b0;
    rd1_gnt = 1'b0;
    if (!rst) begin
      if (rd0_req && rd1_req) begin
        rd0_gnt = (last_q == REQ1);
        rd1_gnt = (last_q == REQ0);
      end else begin
        rd0_gnt = rd0_req;
        rd1_gnt = rd1_req;
      end
    end
  end

  assign ram_we  = wr_en & ~rst;
  assign rd_addr = rd1_gnt ? rd1_addr : rd0_addr;

  dpram_rd_arb_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

`ifdef DPRAM_RD_ARB_BYPASS_EN
  assign rd_word = coll_q ? byp_q : ram_rdata;
`else
  assign rd_word = ram_rdata;
`endif

  always_comb begin
    last_d = last_q;
    if (rd0_gnt) begin
      last_d = REQ0;
    end else if (rd1_gnt) begin
      last_d = REQ1;
    end
    vld0_d  = rd0_gnt;
    vld1_d  = rd1_gnt;
    coll_d  = (rd0_gnt | rd1_gnt) & ram_we & (rd_addr == wr_addr);
    data0_d = vld0_q ? rd_word : data0_q;
    data1_d = vld1_q ? rd_word : data1_q;
`ifdef DPRAM_RD_ARB_BYPASS_EN
    byp_d   = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= REQ1;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      coll_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
`ifdef DPRAM_RD_ARB_BYPASS_EN
      byp_q   <= '0;
`endif
    end else begin
      last_q  <= last_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      coll_q  <= coll_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
`ifdef DPRAM_RD_ARB_BYPASS_EN
      byp_q   <= byp_d;
`endif
    end
  end

  // Reset landing on a valid cycle must swallow that pulse and blank the outputs.
  assign rd0_valid    = vld0_q & ~rst;
  assign rd1_valid    = vld1_q & ~rst;
  assign rd_collision = coll_q & ~rst;
  assign rd0_data     = rst ? '0 : (vld0_q ? rd_word : data0_q);
  assign rd1_data     = rst ? '0 : (vld1_q ? rd_word : data1_q);

endmodule

// File: doc/dpram_rd_arb.md
DPRAM_RD_ARB -- requirements
Module: dpram_rd_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning RAM word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning RAM address width; depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port wr_en  input  1  write strobe.
REQ-006 The block SHALL have ports wr_addr  input  ADDR_WIDTH  and  wr_data  input  DATA_WIDTH, the write address and data.
REQ-007 The block SHALL have ports rd0_req and rd1_req, each  input  1, the read request from requester 0 and requester 1.
REQ-008 The block SHALL have ports rd0_addr and rd1_addr, each  input  ADDR_WIDTH, the read address per requester.
REQ-009 The block SHALL have ports rd0_gnt and rd1_gnt, each  output  1, the combinational grant for the current cycle.
REQ-010 The block SHALL have ports rd0_valid and rd1_valid, each  output  1, a one-cycle read-data-valid pulse.
REQ-011 The block SHALL have ports rd0_data and rd1_data, each  output  DATA_WIDTH, the registered read data.
REQ-012 The block SHALL have port rd_collision  output  1, a one-cycle pulse marking a read that hit the same-cycle write address.

Function
REQ-013 Writes SHALL pass to the RAM write port unarbitrated; wr_en takes effect at the next edge.
REQ-014 At most one of rd0_gnt and rd1_gnt SHALL be high per cycle; gnt is high only when the matching req is high.
REQ-015 Single requester active: that requester SHALL be granted in the same cycle.
REQ-016 Both requesting: the grant SHALL go to the requester not granted most recently (round-robin); the last-grant pointer updates only on a grant.
REQ-017 A granted rdN_addr SHALL drive the RAM read address in the grant cycle; rdN_valid SHALL pulse exactly 1 cycle later with rdN_data = the RAM word.
REQ-018 An ungranted requester SHALL hold req and addr; there is no drop or queue inside the block.
REQ-019 The block SHALL sustain back-to-back grants, so throughput is 1 read/cycle total; with two requesters continuously active, grants alternate 0,1,0,1.
REQ-020 rdN_data SHALL hold its last value between valid pulses.
REQ-021 rd_collision SHALL pulse with the corresponding rdN_valid when the granted address equalled wr_addr with wr_en high in the grant cycle.
REQ-022 A grant idle cycle (no req) SHALL leave the pointer and the data registers unchanged.

Reset
REQ-023 On rst, the block SHALL clear rd0_valid, rd1_valid and rd_collision to 0, clear rd0_data and rd1_data to 0, and set the pointer so that requester 0 wins the first contention.
REQ-024 While rst is high, the block SHALL force gnt outputs to 0 and gate wr_en off; RAM contents are not cleared.
REQ-025 Reset asserted in the cycle after a grant SHALL suppress that grant's valid pulse.

Configuration
REQ-026 Macro DPRAM_RD_ARB_BYPASS_EN defined: on a collision (REQ-021), rdN_data SHALL equal the same-cycle wr_data (write-first forwarding).
REQ-027 Macro DPRAM_RD_ARB_BYPASS_EN undefined: colliding read data SHALL be unspecified; rd_collision still pulses.

Structure
REQ-028 Package dpram_rd_arb_pkg SHALL hold the requester-id constants (REQ0=0, REQ1=1) and the default width constants.
REQ-029 The block SHALL instantiate the existing synchronous dual-port RAM as its sole sub-module, with no RAM logic inlined.

Verification
REQ-030 After reset, a bench SHALL write 0xA5 at address 0x10; rd0 reading 0x10 SHALL give rd0_gnt the same cycle, rd0_valid the next cycle, and rd0_data=0xA5.
REQ-031 A bench SHALL hold rd0 and rd1 active for 6 cycles after reset; grants SHALL be 0,1,0,1,0,1 and each valid SHALL lag its gnt by 1.
REQ-032 A bench SHALL drive rd1 alone for 3 cycles, then both; rd0 SHALL win the first contention.
REQ-033 A bench SHALL set wr_en=1, wr_addr=0x20 and wr_data=0x3C while rd0 reads 0x20; rd_collision SHALL pulse, and with BYPASS_EN rd0_data SHALL be 0x3C.
REQ-034 A bench SHALL assert rst in the cycle after an rd1 grant; no rd1_valid SHALL appear, all outputs SHALL be 0, and previously written data SHALL read back intact after reset.
